multicycle_addsub: RTL and testbench
====================================

MULTICYCLE_ADDSUB -- requirements
Module: multicycle_addsub

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 32: operand and result width in bits.
REQ-002 The module SHALL provide parameter CHUNK, default 8: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port start  input  1  request a new operation; accepted only when busy=0.
REQ-006 The module SHALL have port mode  input  1  0 = add (A+B+Cin), 1 = subtract (A-B).
REQ-007 The module SHALL have ports A and B  input  WIDTH  operands.
REQ-008 The module SHALL have port Cin  input  1  carry-in, used in add mode only.
REQ-009 The module SHALL have port SUM  output  WIDTH  result.
REQ-010 The module SHALL have port Cout  output  1  carry-out of the MSB; in subtract mode 1 = no borrow.
REQ-011 The module SHALL have port OVF  output  1  two's-complement signed overflow.
REQ-012 The module SHALL have port ZERO  output  1  SUM == 0.
REQ-013 The module SHALL have ports busy  output  1  (operation in progress) and done  output  1  (one-cycle result-valid pulse).

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; start is accepted in IDLE and in DONE.
REQ-015 On an accepting edge with start=1, the block SHALL latch A, B, mode and Cin, clear the chunk index to 0, and enter RUN.
REQ-016 Operand capture SHALL invert B and force the initial carry to 1 when mode=1, ignoring Cin; when mode=0 the initial carry SHALL be Cin.
REQ-017 Each RUN edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of both operands plus the stored carry, LSB chunk first, write that SUM slice and update the stored carry.
REQ-018 After the RUN edge that processes chunk N-1, the FSM SHALL enter DONE.
REQ-019 On that same edge, Cout, OVF and ZERO SHALL be registered: OVF = carry into MSB XOR carry out of MSB.
REQ-020 Latency: if start is accepted at edge t, done SHALL be 1 in exactly the cycle following edge t+N, and 0 in all other cycles.
REQ-021 busy SHALL be 1 in the cycles following edges t through t+N-1, and 0 otherwise.
REQ-022 SUM, Cout, OVF and ZERO SHALL hold their final values from DONE until the next accepted start; during RUN their values are undefined to the user.
REQ-023 DONE with start=0 SHALL go to IDLE on the next edge; DONE with start=1 SHALL accept the new operation directly, allowing back-to-back operations every N+1 cycles.
REQ-024 start asserted while busy=1 SHALL be ignored, with no effect on the operation in progress or on the latched operands.
REQ-025 Changes to A, B, mode or Cin after acceptance SHALL NOT affect the operation in progress.
REQ-026 When CHUNK=WIDTH (N=1), the block SHALL produce the result one edge after start, with done in the following cycle.

Reset
REQ-027 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear SUM, Cout, OVF, busy, done and the chunk index to 0, and set ZERO=1.
REQ-028 Reset asserted during RUN SHALL abort the operation, with no done pulse issued for it.
REQ-029 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-030 WIDTH=32, CHUNK=8, add: A=0xFFFFFFFF, B=0x00000000, Cin=1 -> SUM=0x00000000, Cout=1, ZERO=1, OVF=0; done exactly 4 cycles after the start edge.
REQ-031 Subtract: A=5, B=7 -> SUM=0xFFFFFFFE, Cout=0, OVF=0, ZERO=0; subtract A=7, B=5 with Cin=1 -> SUM=0x00000002, Cout=1 (Cin ignored).
REQ-032 Signed overflow: add 0x7FFFFFFF+1, Cin=0 -> SUM=0x80000000, OVF=1, Cout=0; subtract 0x80000000-1 -> SUM=0x7FFFFFFF, OVF=1, Cout=1.
REQ-033 Handshake: pulse start with 1+2; change operands and pulse start again during busy -> single done pulse with SUM=3; start held high in DONE -> next operation completes with no IDLE cycle between.
REQ-034 Reset mid-operation: drop rst_n for one cycle at the 2nd RUN cycle -> no done pulse, all outputs at reset values (ZERO=1); a following start for 10+20 -> SUM=30 after N+1 cycles.
REQ-035 Parameter sweep with CHUNK in {1, 4, 32} at WIDTH=32 over 1000 random add/sub operations -> every result matches the reference model, and done latency equals WIDTH/CHUNK cycles.

Source files
------------

// File: rtl/multicycle_addsub.sv
// ---------------------------------------------------------------------------
// multicycle_addsub
//
// Sequential adder/subtractor.  A WIDTH-bit add or subtract is carried out
// CHUNK bits per clock, least significant chunk first, with the chunk carry
// held in a register between cycles.  An operation takes N = WIDTH/CHUNK
// RUN cycles followed by a one-cycle DONE state.  From DONE a new start is
// taken directly, so operations can be issued every N+1 cycles.
// WIDTH must be an integer multiple of CHUNK.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request a new operation (taken in IDLE or DONE only)
//   mode   in   1      0 = A+B+Cin, 1 = A-B
//   A, B   in   WIDTH  operands, captured when start is taken
//   Cin    in   1      carry-in, add mode only
//   SUM    out  WIDTH  result
//   Cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   OVF    out  1      two's-complement signed overflow
//   ZERO   out  1      SUM == 0
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, result valid
// ---------------------------------------------------------------------------
module multicycle_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout,
    output logic             OVF,
    output logic             ZERO,
    output logic             busy,
    output logic             done
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtract
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry_in;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        // Slice of the current chunk and its sum with the stored carry.
        base      = int'(idx_q) * CHUNK;
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of the chunk, recovered from the sum bit.
        msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtract is A + ~B + 1; Cin is ignored in that mode.
                    a_d     = A;
                    b_d     = mode ? ~B : B;
                    carry_d = mode ? 1'b1 : Cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d              = chunk_sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    // Final chunk holds the MSB: flags come from this edge.
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
                    zero_d  = (sum_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SUM  = sum_q;
    assign Cout = cout_q;
    assign OVF  = ovf_q;
    assign ZERO = zero_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_multicycle_addsub.sv
// ---------------------------------------------------------------------------
// tb_multicycle_addsub
//
// Four instances of multicycle_addsub (CHUNK = 8, 1, 4, 32 at WIDTH = 32)
// share operands and reset; each has its own start.  Only one instance is
// exercised at a time (index cur).  Every issued operation pushes its
// expected result and completion edge into a queue; a monitor on the
// falling edge checks busy for every instance and, on done, pops and
// compares SUM/Cout/OVF/ZERO and latency.
// ---------------------------------------------------------------------------
module tb_multicycle_addsub;

    localparam int WIDTH = 32;
    localparam int NI    = 4;
    localparam logic [NI-1:0][5:0] CHUNK_TAB = {6'd32, 6'd4, 6'd1, 6'd8};

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          done_edge;
    } exp_t;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NI-1:0]        start_s = '0;
    logic                 mode  = 1'b0;
    logic                 cin   = 1'b0;
    logic [31:0]          a_in  = '0;
    logic [31:0]          b_in  = '0;
    logic [NI-1:0][31:0]  sum_s;
    logic [NI-1:0]        cout_s;
    logic [NI-1:0]        ovf_s;
    logic [NI-1:0]        zero_s;
    logic [NI-1:0]        busy_s;
    logic [NI-1:0]        done_s;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   cur      = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            multicycle_addsub #(
                .WIDTH(WIDTH),
                .CHUNK(int'(CHUNK_TAB[gi]))
            ) u_dut (
                .clk  (clk),
                .rst_n(rst_n),
                .start(start_s[gi]),
                .mode (mode),
                .A    (a_in),
                .B    (b_in),
                .Cin  (cin),
                .SUM  (sum_s[gi]),
                .Cout (cout_s[gi]),
                .OVF  (ovf_s[gi]),
                .ZERO (zero_s[gi]),
                .busy (busy_s[gi]),
                .done (done_s[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic int nch(int u);
        return WIDTH / int'(CHUNK_TAB[u]);
    endfunction

    // Reference: plain wide arithmetic on the whole operands.
    function automatic exp_t model(logic m, logic [31:0] a, logic [31:0] b, logic c);
        exp_t        r;
        logic [32:0] full;
        if (!m) begin
            full   = {1'b0, a} + {1'b0, b} + {32'd0, c};
            r.sum  = full[31:0];
            r.cout = full[32];
            r.ovf  = (a[31] == b[31]) && (r.sum[31] != a[31]);
        end else begin
            r.sum  = a - b;
            r.cout = (a >= b);
            r.ovf  = (a[31] != b[31]) && (r.sum[31] != a[31]);
        end
        r.zero      = (r.sum == 32'd0);
        r.done_edge = 0;
        return r;
    endfunction

    function automatic exp_t lit(logic [31:0] s, logic co, logic ov, logic z);
        exp_t r;
        r.sum       = s;
        r.cout      = co;
        r.ovf       = ov;
        r.zero      = z;
        r.done_edge = 0;
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(string name, int u, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d (CHUNK=%0d) edge %0d: got %h expected %h",
                     name, u, int'(CHUNK_TAB[u]), edge_cnt, got, want);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check_reset(int u);
        check("rst_SUM",  u, sum_s[u], 32'd0);
        check("rst_Cout", u, 32'(cout_s[u]), 32'd0);
        check("rst_OVF",  u, 32'(ovf_s[u]), 32'd0);
        check("rst_ZERO", u, 32'(zero_s[u]), 32'd1);
        check("rst_busy", u, 32'(busy_s[u]), 32'd0);
        check("rst_done", u, 32'(done_s[u]), 32'd0);
    endtask

    // Called at a falling edge: holds start over exactly one rising edge,
    // then scrambles the operand inputs to show they are no longer used.
    task automatic issue(int u, logic m, logic [31:0] a, logic [31:0] b, logic c, exp_t e);
        mode        = m;
        a_in        = a;
        b_in        = b;
        cin         = c;
        start_s[u]  = 1'b1;
        e.done_edge = edge_cnt + 1 + nch(u);
        sb_q.push_back(e);
        @(negedge clk);
        start_s[u] = 1'b0;
        a_in       = $urandom;
        b_in       = $urandom;
        mode       = 1'($urandom_range(0, 1));
        cin        = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(int u);
        int k = 0;
        while (!done_s[u] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done_s[u]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout inst%0d: got no done in %0d cycles, expected one", u, k);
            finish_sim();
        end
    endtask

    task automatic wait_drain(int u);
        int k = 0;
        while (sb_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout inst%0d: got %0d pending results, expected 0", u, sb_q.size());
            finish_sim();
        end
        // Idle tail so any stray done is seen by the monitor.
        repeat (nch(u) + 2) @(negedge clk);
    endtask

    task automatic run_random(int u, int nops);
        logic        m;
        logic        c;
        logic [31:0] a;
        logic [31:0] b;
        cur = u;
        @(negedge clk);
        for (int n = 0; n < nops; n++) begin
            m = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            a = rand_operand();
            b = rand_operand();
            issue(u, m, a, b, c, model(m, a, b, c));
            wait_done(u);
            // Half the time the next op is issued in DONE (back-to-back).
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_drain(u);
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    always @(negedge clk) begin : mon
        logic exp_busy;
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            exp_busy = 1'b0;
            if (i == cur && sb_q.size() > 0)
                exp_busy = (edge_cnt >= sb_q[0].done_edge - nch(i)) &&
                           (edge_cnt <  sb_q[0].done_edge);
            check("busy", i, 32'(busy_s[i]), 32'(exp_busy));
            if (done_s[i]) begin
                if (i != cur || sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst%0d edge %0d: got done=1 expected done=0", i, edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", i, 32'(edge_cnt), 32'(e.done_edge));
                    check("SUM",  i, sum_s[i], e.sum);
                    check("Cout", i, 32'(cout_s[i]), 32'(e.cout));
                    check("OVF",  i, 32'(ovf_s[i]), 32'(e.ovf));
                    check("ZERO", i, 32'(zero_s[i]), 32'(e.zero));
                    $display("op inst%0d CHUNK=%0d edge=%0d SUM=%h Cout=%b OVF=%b ZERO=%b",
                             i, int'(CHUNK_TAB[i]), edge_cnt, sum_s[i], cout_s[i], ovf_s[i], zero_s[i]);
                end
            end else if (i == cur && sb_q.size() > 0 && edge_cnt >= sb_q[0].done_edge) begin
                checks++;
                errors++;
                $display("FAIL missing_done inst%0d edge %0d: got done=0 expected done=1", i, edge_cnt);
                e = sb_q.pop_front();
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin : stim
        logic        dm  [5];
        logic [31:0] da  [5];
        logic [31:0] db  [5];
        logic        dc  [5];
        exp_t        de  [5];

        // Reset with start asserted: start must be ignored.
        cur        = 0;
        rst_n      = 1'b0;
        start_s[0] = 1'b1;
        a_in       = 32'd1;
        b_in       = 32'd2;
        repeat (3) @(negedge clk);
        rst_n      = 1'b1;
        start_s    = '0;
        for (int u = 0; u < NI; u++) check_reset(u);
        repeat (3) @(negedge clk);

        // Directed vectors with literal expectations.
        dm[0] = 1'b0; da[0] = 32'hFFFF_FFFF; db[0] = 32'h0000_0000; dc[0] = 1'b1;
        de[0] = lit(32'h0000_0000, 1'b1, 1'b0, 1'b1);
        dm[1] = 1'b1; da[1] = 32'd5;         db[1] = 32'd7;         dc[1] = 1'b0;
        de[1] = lit(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        dm[2] = 1'b1; da[2] = 32'd7;         db[2] = 32'd5;         dc[2] = 1'b1;
        de[2] = lit(32'h0000_0002, 1'b1, 1'b0, 1'b0);
        dm[3] = 1'b0; da[3] = 32'h7FFF_FFFF; db[3] = 32'd1;         dc[3] = 1'b0;
        de[3] = lit(32'h8000_0000, 1'b0, 1'b1, 1'b0);
        dm[4] = 1'b1; da[4] = 32'h8000_0000; db[4] = 32'd1;         dc[4] = 1'b0;
        de[4] = lit(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            issue(0, dm[k], da[k], db[k], dc[k], de[k]);
            wait_drain(0);
        end

        // start during busy with new operands: ignored, single done with 3.
        issue(0, 1'b0, 32'd1, 32'd2, 1'b0, lit(32'd3, 1'b0, 1'b0, 1'b0));
        mode       = 1'b1;
        a_in       = 32'd100;
        b_in       = 32'd200;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_drain(0);

        // Back-to-back: second start taken in DONE, no IDLE cycle between.
        issue(0, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1,
              model(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1));
        wait_done(0);
        issue(0, 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0,
              model(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0));
        wait_drain(0);

        // Reset during the second RUN cycle aborts the operation.
        issue(0, 1'b0, 32'h1234_5678, 32'h0101_0101, 1'b0, lit(32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check_reset(0);
        repeat (nch(0) + 3) @(negedge clk);
        issue(0, 1'b0, 32'd10, 32'd20, 1'b0, lit(32'd30, 1'b0, 1'b0, 1'b0));
        wait_drain(0);

        // Randomised sweep over all chunk sizes.
        run_random(0, 200);
        run_random(1, 1000);
        run_random(2, 1000);
        run_random(3, 1000);

        finish_sim();
    end

endmodule
